cic_capture_ctrl: RTL
=====================

Name: cic_capture_ctrl

Overview:
Sequencing controller for cic_decimator. Enables the decimator on a start request and discards the first decimated outputs while the integrator/comb pipeline settles. It then optionally waits for a trigger and writes a programmed number of decimated samples into the sample RAM. It sits between the acquisition control registers and the decimator/sample-RAM pair.

Parameters:
DATA_WIDTH, 16, width of decimated sample (matches decimator data_out)
ADDR_WIDTH, 10, sample RAM address width; maximum capture 2^ADDR_WIDTH samples
SETTLE_COUNT, 4, decimated outputs discarded after enable (0 = no settle phase)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a capture
abort  in  1  one-cycle request to cancel the capture in progress
trigger_en  in  1  1 = wait for trigger before capturing; 0 = capture right after settle
trigger  in  1  trigger event, sampled every clk
capture_len  in  ADDR_WIDTH  number of samples to capture, minus 1
dec_enabled  out  1  drives decimator enabled
dec_strobe  in  1  one-clk pulse per decimated output, synchronous to clk (decimator clk_transfer)
dec_data  in  DATA_WIDTH  decimated sample, valid while dec_strobe=1
wr_en  out  1  sample RAM write strobe
wr_addr  out  ADDR_WIDTH  sample RAM write address
wr_data  out  DATA_WIDTH  sample RAM write data
busy  out  1  high in SETTLE, ARMED and CAPTURE
done  out  1  capture complete; held until the next accepted start
sample_count  out  ADDR_WIDTH+1  samples written in the current/last capture

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, all counters 0.
- States: IDLE, SETTLE, ARMED, CAPTURE, DONE. All outputs are registered.
- IDLE/DONE:
  - start=1 latches capture_len and trigger_en.
  - Clears done, sample_count and settle_cnt.
  - dec_enabled=1 and busy=1 from the next cycle.
  - Next state is SETTLE, or directly ARMED/CAPTURE if SETTLE_COUNT=0.
- SETTLE:
  - Each dec_strobe increments settle_cnt. No writes.
  - On the strobe that brings settle_cnt to SETTLE_COUNT, go to ARMED if latched trigger_en=1, else CAPTURE.
  - That strobe's sample is discarded.
- ARMED:
  - trigger=1 moves to CAPTURE.
  - If dec_strobe=1 in the same cycle as trigger, that sample is captured as sample 0.
  - Strobes without trigger are discarded.
- CAPTURE:
  - Each dec_strobe produces, one cycle later: wr_en=1 (single cycle), wr_addr=sample_count[ADDR_WIDTH-1:0], wr_data=dec_data, sample_count+1.
  - Strobe-to-write latency is exactly 1 clk.
  - When the strobe for sample index capture_len is accepted, go to DONE. That sample's write still occurs the following cycle.
- DONE: dec_enabled=0, busy=0, done=1, sample_count holds the final value (capture_len+1).
- capture_len all-ones captures 2^ADDR_WIDTH samples. wr_addr never wraps within a capture.
- start while busy=1 is ignored.
- abort=1 in SETTLE/ARMED/CAPTURE:
  - Next cycle: state IDLE, dec_enabled=0, busy=0, done stays 0.
  - A strobe in the abort cycle is not written. A write already pending from the previous cycle's strobe still completes.
  - sample_count holds the partial count.
  - abort takes priority over trigger, strobe and start in the same cycle.
  - abort in IDLE/DONE has no effect.
- dec_strobe is ignored in IDLE and DONE.
- Back-to-back strobes on consecutive cycles are supported, giving consecutive writes.

Test Plan:
- Basic capture (SETTLE_COUNT=4, ADDR_WIDTH=4, trigger_en=0, capture_len=7; strobe every 4 clk, dec_data=0x0010+k):
  - First 4 strobes discarded.
  - 8 writes at addr 0..7 carrying data 0x0014..0x001B, each 1 clk after its strobe.
  - done=1, sample_count=8, dec_enabled=0.
- Triggered capture (trigger_en=1, capture_len=3; trigger pulsed 3 strobes after settle, coincident with a strobe carrying 0x0100):
  - addr0=0x0100, then the next 3 strobe values at addr 1..3.
  - Nothing written before the trigger.
- Abort mid-capture (capture_len=15; abort after 5 writes, in a cycle with dec_strobe=1):
  - No 6th write; IDLE next cycle; busy=0, done=0, sample_count=5.
  - A following start yields a clean capture from addr 0.
- Full-depth wrap boundary (ADDR_WIDTH=4, capture_len=15, strobe every clk):
  - 16 consecutive writes at addr 0..15; sample_count=16.
  - No write to addr 0 after addr 15.
- Start while busy / SETTLE_COUNT=0:
  - start pulses during CAPTURE have no effect.
  - With SETTLE_COUNT=0 and trigger_en=0, the first strobe after start is written at addr 0.
- Async reset mid-CAPTURE:
  - rst_n low between clock edges clears wr_en, busy, done, dec_enabled and sample_count immediately (before the next clk edge).

Source files
------------

// File: rtl/cic_capture_ctrl_if.sv
// ============================================================================
// Module      : cic_capture_ctrl_if
// Description : Decimator handshake and sample-RAM write bus of the capture
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cic_capture_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  dec_enabled;
    logic                  dec_strobe;
    logic [DATA_WIDTH-1:0] dec_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output dec_enabled,
        input  dec_strobe,
        input  dec_data,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  dec_enabled,
        output dec_strobe,
        output dec_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

`default_nettype wire

// File: rtl/cic_capture_ctrl.sv
// ============================================================================
// Module      : cic_capture_ctrl
// Description : Enables the CIC decimator, discards settling outputs, waits
//               for an optional trigger and writes a capture into sample RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_capture_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int SETTLE_COUNT = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_start,
    input  wire logic                  i_abort,
    input  wire logic                  i_trigger_en,
    input  wire logic                  i_trigger,
    input  wire logic [ADDR_WIDTH-1:0] i_capture_len,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [ADDR_WIDTH:0]        o_sample_count,
    cic_capture_ctrl_if.master         bus
);

    localparam int c_SW = (SETTLE_COUNT > 0) ? $clog2(SETTLE_COUNT + 1) : 1;
    localparam logic [c_SW-1:0] c_SETTLE_TGT = c_SW'(SETTLE_COUNT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_ARMED   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_len, w_len;
    logic                  r_trig_en, w_trig_en;
    logic [c_SW-1:0]       r_settle_cnt, w_settle_cnt;
    logic [ADDR_WIDTH:0]   r_count, w_count;
    logic                  r_wr_en, w_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data;
    logic                  r_dec_en, w_dec_en;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  w_take;
    logic                  w_abort;

    always_comb begin
        w_state      = r_state;
        w_len        = r_len;
        w_trig_en    = r_trig_en;
        w_settle_cnt = r_settle_cnt;
        w_count      = r_count;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_addr;
        w_wr_data    = r_wr_data;
        w_dec_en     = r_dec_en;
        w_busy       = r_busy;
        w_done       = r_done;
        w_take       = 1'b0;
        w_abort      = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_len        = i_capture_len;
                    w_trig_en    = i_trigger_en;
                    w_done       = 1'b0;
                    w_count      = '0;
                    w_settle_cnt = '0;
                    w_dec_en     = 1'b1;
                    w_busy       = 1'b1;
                    if (SETTLE_COUNT == 0) begin
                        w_state = i_trigger_en ? S_ARMED : S_CAPTURE;
                    end else begin
                        w_state = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (i_abort) begin
                    w_abort = 1'b1;
                end else if (bus.dec_strobe) begin
                    w_settle_cnt = r_settle_cnt + 1'b1;
                    if (w_settle_cnt == c_SETTLE_TGT) begin
                        w_state = r_trig_en ? S_ARMED : S_CAPTURE;
                    end
                end
            end
            S_ARMED: begin
                if (i_abort) begin
                    w_abort = 1'b1;
                end else if (i_trigger) begin
                    w_state = S_CAPTURE;
                    w_take  = bus.dec_strobe;
                end
            end
            S_CAPTURE: begin
                if (i_abort) begin
                    w_abort = 1'b1;
                end else begin
                    w_take = bus.dec_strobe;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // The write and count update land one clock after the accepted strobe;
        // the low count bits are the address, so a full-depth capture never wraps.
        if (w_take) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_count[ADDR_WIDTH-1:0];
            w_wr_data = bus.dec_data;
            w_count   = r_count + 1'b1;
            if (r_count[ADDR_WIDTH-1:0] == r_len) begin
                w_state  = S_DONE;
                w_dec_en = 1'b0;
                w_busy   = 1'b0;
                w_done   = 1'b1;
            end
        end

        if (w_abort) begin
            w_state  = S_IDLE;
            w_dec_en = 1'b0;
            w_busy   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_trig_en    <= 1'b0;
            r_settle_cnt <= '0;
            r_count      <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_dec_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_len        <= w_len;
            r_trig_en    <= w_trig_en;
            r_settle_cnt <= w_settle_cnt;
            r_count      <= w_count;
            r_wr_en      <= w_wr_en;
            r_wr_addr    <= w_wr_addr;
            r_wr_data    <= w_wr_data;
            r_dec_en     <= w_dec_en;
            r_busy       <= w_busy;
            r_done       <= w_done;
        end
    end

    assign bus.dec_enabled = r_dec_en;
    assign bus.wr_en       = r_wr_en;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_sample_count  = r_count;

endmodule

`default_nettype wire
